// File: rtl/sobel_edge_filter.sv
// Three-stage Sobel edge filter over a streamed 3x3 window, with per-frame
// output position tracking (end-of-line / end-of-frame flags).
module sobel_edge_filter #(
  parameter int ITEM_SIZE    = 8,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [9*ITEM_SIZE-1:0] pixel_data_in,
  input  logic                   pixel_data_in_valid,
  input  logic [ITEM_SIZE-1:0]   threshold,
  input  logic                   binary_mode,
  output logic [ITEM_SIZE-1:0]   edge_out,
  output logic                   edge_out_valid,
  output logic                   edge_eol,
  output logic                   edge_eof
);

  localparam int SW = ITEM_SIZE + 2;
  localparam int MW = ITEM_SIZE + 3;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 3);
  localparam logic [MW-1:0] SAT_MAX  = {3'b000, {ITEM_SIZE{1'b1}}};

  logic [ITEM_SIZE-1:0] p [9];
  logic [2:0]           vld;

  logic [SW-1:0] gx_pos_q, gx_neg_q, gy_pos_q, gy_neg_q;
  logic [SW-1:0] abs_gx_q, abs_gy_q;

  logic [MW-1:0]        mag;
  logic [ITEM_SIZE-1:0] sat;
  logic [ITEM_SIZE-1:0] pix;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          last_col;
  logic          last_row;

  function automatic logic [SW-1:0] wsum(input logic [ITEM_SIZE-1:0] a,
                                         input logic [ITEM_SIZE-1:0] b,
                                         input logic [ITEM_SIZE-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [SW-1:0] absdiff(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      p[i] = pixel_data_in[ITEM_SIZE*i +: ITEM_SIZE];
    end
  end

  assign edge_out_valid = vld[2];

  // Stage 1 and 2 run every cycle; bubbles carry don't-care data with valid low.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld      <= '0;
      gx_pos_q <= '0;
      gx_neg_q <= '0;
      gy_pos_q <= '0;
      gy_neg_q <= '0;
      abs_gx_q <= '0;
      abs_gy_q <= '0;
    end else begin
      vld      <= {vld[1:0], pixel_data_in_valid};
      gx_pos_q <= wsum(p[2], p[5], p[8]);
      gx_neg_q <= wsum(p[0], p[3], p[6]);
      gy_pos_q <= wsum(p[6], p[7], p[8]);
      gy_neg_q <= wsum(p[0], p[1], p[2]);
      abs_gx_q <= absdiff(gx_pos_q, gx_neg_q);
      abs_gy_q <= absdiff(gy_pos_q, gy_neg_q);
    end
  end

  always_comb begin
    mag = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};
    sat = (mag > SAT_MAX) ? '1 : mag[ITEM_SIZE-1:0];
    if (binary_mode) begin
      pix = (sat >= threshold) ? '1 : '0;
    end else begin
      pix = sat;
    end
    last_col = (col_cnt == COL_LAST);
    last_row = (row_cnt == ROW_LAST);
  end

  // Output stage: edge_out holds between valid outputs, flags are single-cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      edge_out <= '0;
      edge_eol <= 1'b0;
      edge_eof <= 1'b0;
      col_cnt  <= '0;
      row_cnt  <= '0;
    end else begin
      edge_eol <= 1'b0;
      edge_eof <= 1'b0;
      if (vld[1]) begin
        edge_out <= pix;
        edge_eol <= last_col;
        edge_eof <= last_col && last_row;
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Bench for sobel_edge_filter: directed and random windows checked against
// an integer Sobel model with a due-cycle scoreboard.
module tb_sobel_edge_filter;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic [71:0] pixel_data_in;
  logic        pixel_data_in_valid;
  logic [7:0]  threshold;
  logic        binary_mode;
  logic [7:0]  edge_out;
  logic        edge_out_valid;
  logic        edge_eol;
  logic        edge_eof;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_edge_filter #(
    .ITEM_SIZE    (8),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clk                 (clk),
    .rstN                (rstN),
    .pixel_data_in       (pixel_data_in),
    .pixel_data_in_valid (pixel_data_in_valid),
    .threshold           (threshold),
    .binary_mode         (binary_mode),
    .edge_out            (edge_out),
    .edge_out_valid      (edge_out_valid),
    .edge_eol            (edge_eol),
    .edge_eof            (edge_eof)
  );

  typedef struct {
    int          due;
    logic [71:0] win;
    int          want;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         nout     = 0;
  logic [7:0] last_out = '0;
  logic [7:0] cur_thr  = '0;
  logic       cur_bm   = 1'b0;

  function automatic int model_mag(input logic [71:0] w);
    int px[3][3];
    int gx;
    int gy;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px[r][c] = int'(w[8*(3*r+c) +: 8]);
      end
    end
    gx = (px[0][2] - px[0][0]) + 2*(px[1][2] - px[1][0]) + (px[2][2] - px[2][0]);
    gy = (px[2][0] - px[0][0]) + 2*(px[2][1] - px[0][1]) + (px[2][2] - px[0][2]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int model_pix(input int mag, input int thr, input bit bm);
    int sat;
    sat = (mag > 255) ? 255 : mag;
    if (bm) return (sat >= thr) ? 255 : 0;
    return sat;
  endfunction

  function automatic logic [71:0] mkwin(input int c0, input int c1, input int c2);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      w[8*(3*r)   +: 8] = 8'(c0);
      w[8*(3*r+1) +: 8] = 8'(c1);
      w[8*(3*r+2) +: 8] = 8'(c2);
    end
    return w;
  endfunction

  function automatic logic [71:0] rndwin();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) begin
      w[8*i +: 8] = 8'($urandom_range(0, 255));
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    int   expv;
    bit   eol;
    bit   eof;
    if (q.size() != 0 && q[0].due == cyc) begin
      e    = q.pop_front();
      expv = model_pix(model_mag(e.win), int'(threshold), binary_mode);
      eol  = (nout % W) == W - 1;
      eof  = eol && ((nout / W) % (H - 2)) == H - 3;
      nout++;
      chk("out_valid", 32'(edge_out_valid), 32'd1);
      chk("edge_out", 32'(edge_out), 32'(expv));
      if (e.want >= 0) chk("directed", 32'(edge_out), 32'(e.want));
      chk("eol", 32'(edge_eol), 32'(eol));
      chk("eof", 32'(edge_eof), 32'(eof));
      last_out = 8'(expv);
    end else begin
      chk("bubble_valid", 32'(edge_out_valid), 32'd0);
      chk("hold", 32'(edge_out), 32'(last_out));
      chk("bubble_eol", 32'(edge_eol), 32'd0);
      chk("bubble_eof", 32'(edge_eof), 32'd0);
    end
  endtask

  task automatic step(input logic [71:0] win, input bit v, input logic [7:0] thr,
                      input bit bm, input int want);
    @(negedge clk);
    pixel_data_in       = win;
    pixel_data_in_valid = v;
    threshold           = thr;
    binary_mode         = bm;
    cur_thr             = thr;
    cur_bm              = bm;
    @(posedge clk);
    #1;
    if (v) q.push_back('{cyc + 2, win, want});
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, cur_thr, cur_bm, -1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(edge_out_valid), 32'd0);
    chk({tag, "_edge_out"}, 32'(edge_out), 32'd0);
    chk({tag, "_eol"}, 32'(edge_eol), 32'd0);
    chk({tag, "_eof"}, 32'(edge_eof), 32'd0);
  endtask

  initial begin
    rstN                = 1'b1;
    pixel_data_in       = '0;
    pixel_data_in_valid = 1'b0;
    threshold           = '0;
    binary_mode         = 1'b0;
    #2 rstN = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk);
    rstN = 1'b1;
    idle(2);

    // Directed windows: flat, saturated vertical step, weak edge at threshold boundary
    step(mkwin(100, 100, 100), 1'b1, 8'd0, 1'b0, 0);
    idle(4);
    step(mkwin(0, 128, 255), 1'b1, 8'd0, 1'b0, 255);
    idle(4);
    step(mkwin(0, 10, 10), 1'b1, 8'd40, 1'b1, 255);
    idle(4);
    step(mkwin(0, 10, 10), 1'b1, 8'd41, 1'b1, 0);
    idle(4);
    step(mkwin(0, 10, 10), 1'b1, 8'd41, 1'b0, 40);
    idle(4);

    // Back-to-back stream with a 2-cycle gap after the third window
    for (int i = 0; i < 6; i++) begin
      if (i == 3) idle(2);
      step(rndwin(), 1'b1, 8'($urandom), 1'($urandom), -1);
    end
    idle(4);

    // Random stream with bubbles and per-cycle threshold/mode changes
    repeat (80) begin
      step(rndwin(), $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), -1);
    end
    idle(4);

    // Asynchronous reset with two windows in flight
    step(mkwin(0, 128, 255), 1'b1, 8'd0, 1'b0, 255);
    idle(3);
    step(rndwin(), 1'b1, 8'd0, 1'b0, -1);
    step(rndwin(), 1'b1, 8'd0, 1'b0, -1);
    pixel_data_in_valid = 1'b0;
    #2 rstN = 1'b0;
    #1 check_reset_state("midreset");
    q.delete();
    nout     = 0;
    last_out = '0;
    @(negedge clk);
    rstN = 1'b1;
    idle(6);
    repeat (W) step(rndwin(), 1'b1, 8'($urandom), 1'($urandom), -1);
    step(mkwin(0, 128, 255), 1'b1, 8'd0, 1'b0, 255);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_edge_filter.md
Name: sobel_edge_filter

Overview:
Sits directly downstream of the 3-line pixel loader. It consumes one 3x3 pixel window per valid cycle and computes the horizontal and vertical Sobel gradients. It emits one edge pixel per window, either as a saturated gradient magnitude or as a thresholded binary value. It also tracks window position in the frame and flags end-of-line and end-of-frame to the downstream writer.

Parameters:
ITEM_SIZE, 8, bits per pixel.
IMAGE_WIDTH, 512, windows per output row (one per loader read cycle).
IMAGE_HEIGHT, 512, input image rows; output rows = IMAGE_HEIGHT-2.

Ports:
clk  input  1  clock.
rstN  input  1  reset, asynchronous, active-low.
pixel_data_in  input  9*ITEM_SIZE  3x3 window, unsigned pixels.
pixel_data_in_valid  input  1  window valid this cycle.
threshold  input  ITEM_SIZE  binary-mode threshold, sampled every cycle at pipeline stage 3.
binary_mode  input  1  1 = binary output, 0 = saturated magnitude.
edge_out  output  ITEM_SIZE  edge pixel.
edge_out_valid  output  1  edge_out valid.
edge_eol  output  1  qualifies edge_out_valid; last pixel of an output row.
edge_eof  output  1  qualifies edge_out_valid; last pixel of the frame.

Behaviour:
- Window layout: pixel p[i] occupies bits [ITEM_SIZE*(i+1)-1 : ITEM_SIZE*i], i = 0..8, with i = 3*row + col.
- Row 0 is the oldest line, held in slice bits [3*ITEM_SIZE-1:0]. Col 0 is the leftmost pixel.
- Reset: asynchronous, active-low. All pipeline registers, valid bits, counters and outputs clear to 0 immediately on rstN low, regardless of clock.
- No backpressure. The pipeline advances every clock. Invalid cycles propagate as bubbles with valid = 0.
- Stage 1 (registered): compute partial sums.
  - Gx_pos = p2 + 2*p5 + p8
  - Gx_neg = p0 + 2*p3 + p6
  - Gy_pos = p6 + 2*p7 + p8
  - Gy_neg = p0 + 2*p1 + p2
  - Each sum is unsigned, ITEM_SIZE+2 bits, so it cannot overflow.
- Stage 2 (registered): absolute differences.
  - |Gx| = larger minus smaller of Gx_pos/Gx_neg; |Gy| likewise. Each is ITEM_SIZE+2 bits unsigned, max 1020.
  - No signed arithmetic is required.
- Stage 3 (registered): mag = |Gx| + |Gy|, ITEM_SIZE+3 bits, max 2040.
  - sat = mag clamped to 2^ITEM_SIZE-1.
  - If binary_mode = 1: edge_out = all-ones when sat >= threshold, else 0.
  - If binary_mode = 0: edge_out = sat.
  - binary_mode and threshold are sampled in stage 3 of the same cycle, so a change affects only outputs produced from that cycle onward.
- Latency: exactly 3 clocks from a pixel_data_in_valid cycle to the matching edge_out_valid. Valid shifts through a 3-bit shift register.
- When edge_out_valid = 0, edge_out holds its last value. edge_eol and edge_eof are 0.
- Position tracking (stage-3 valid outputs only):
  - col_cnt counts 0..IMAGE_WIDTH-1.
  - row_cnt counts 0..IMAGE_HEIGHT-3.
  - edge_eol = 1 when col_cnt == IMAGE_WIDTH-1. col_cnt then wraps to 0 and row_cnt increments.
  - edge_eof = 1 when edge_eol = 1 and row_cnt == IMAGE_HEIGHT-3. Both counters then wrap to 0, ready for the next frame.
  - Counters advance only on output-valid cycles. Gaps between rows (loader idle) do not disturb them.
- Reset mid-frame: counters restart at 0. In-flight windows are discarded, with no partial output after rstN releases.
- Counter widths: $clog2(IMAGE_WIDTH) and $clog2(IMAGE_HEIGHT). Comparisons are exact, so no wrap occurs before the terminal value.

Test Plan:
- Flat window, all p = 100, valid 1 cycle, binary_mode = 0 -> exactly 3 clocks later edge_out_valid = 1, edge_out = 0; valid low on every other cycle.
- Vertical step: col 0 = 0, col 2 = 255, col 1 = 128, binary_mode = 0 -> |Gx| = 1020, |Gy| = 0, edge_out = 255 (saturated).
- Weak edge: col 0 = 0, cols 1-2 = 10, binary_mode = 1 -> |Gx| = 40; threshold = 40 gives edge_out = 255, threshold = 41 gives edge_out = 0. Repeat with magnitude mode -> edge_out = 40.
- Back-to-back stream of 6 windows with a 2-cycle gap after the 3rd -> 6 outputs in order, same gap pattern, each 3 clocks after its input.
- Frame sequencing: IMAGE_WIDTH = 4, IMAGE_HEIGHT = 4, stream 8 windows -> edge_eol on outputs 4 and 8, edge_eof only on output 8. A 9th window yields col 0 / row 0 with no flags.
- Assert rstN low asynchronously (mid-cycle) while 2 windows are in flight -> outputs and valid drop to 0 immediately. After release, no stale outputs appear, and the next window reports col_cnt from 0 (eol after IMAGE_WIDTH outputs).
